ddr_wr_arbiter: RTL and testbench



---
 rtl/ddr_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_ddr_wr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter sharing the single DDR write channel between NUM_CH
// write clients, one burst at a time.
//
// state | meaning
// IDLE  | no owner; arbitrate when wready=1 and any client requests
// DATA  | owner's beats forwarded until BEATS beats have passed
// WAIT  | forwarding off; wait for write path to go busy then ready again
module ddr_wr_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_CH-1:0]            ch_req,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
   input  logic [NUM_CH*LEN_WIDTH-1:0]  ch_len,
   output logic [NUM_CH-1:0]            ch_gnt,
   output logic [NUM_CH-1:0]            ch_busy,
   input  logic [NUM_CH-1:0]            ch_wdata_vld,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
   output logic                         wstart,
   input  logic                         wready,
   output logic [ADDR_WIDTH-1:0]        waddr,
   output logic [LEN_WIDTH-1:0]         wdata_len,
   output logic                         wdata_vld,
   output logic [DATA_WIDTH-1:0]        wdata
);

   localparam int IDXW   = $clog2(NUM_CH);
   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int BSHIFT = $clog2(BYTES);
   localparam int CNTW   = LEN_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] last_q, owner_q, sel;
   logic            sel_vld;
   logic [CNTW-1:0] beats_q, cnt_q, sel_beats;
   logic            seen_busy_q;
   logic            arb_go, beat_fwd, owner_vld;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [LEN_WIDTH-1:0]  sel_len;
   logic [DATA_WIDTH-1:0] owner_data;

   // Round-robin search starting one past the last granted channel
   always_comb begin
      int idx;
      sel     = last_q;
      sel_vld = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = (int'(last_q) + k) % NUM_CH;
         if (!sel_vld && ch_req[IDXW'(idx)]) begin
            sel     = IDXW'(idx);
            sel_vld = 1'b1;
         end
      end
   end

   assign sel_addr   = ch_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_len    = ch_len[sel*LEN_WIDTH +: LEN_WIDTH];
   // One extra bit so a length of all-ones cannot wrap when rounding up
   assign sel_beats  = ({1'b0, sel_len} + CNTW'(BYTES - 1)) >> BSHIFT;
   assign owner_vld  = ch_wdata_vld[owner_q];
   assign owner_data = ch_wdata[owner_q*DATA_WIDTH +: DATA_WIDTH];

   // No arbitration while a grant pulse is out: the granted client still
   // shows its request during that cycle and must not be granted twice.
   assign arb_go   = (state_q == IDLE) && wready && sel_vld && (ch_gnt == '0);
   assign beat_fwd = (state_q == DATA) && owner_vld && (cnt_q < beats_q);

   assign ch_busy  = (state_q == IDLE) ? '0 : (NUM_CH'(1) << owner_q);

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arb_go && (sel_len != '0)) state_d = DATA;
         DATA:    if (beat_fwd && ((cnt_q + CNTW'(1)) == beats_q)) state_d = WAIT;
         WAIT:    if (wready && seen_busy_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant/start pulses, burst parameters, beat forwarding and busy tracking
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ch_gnt      <= '0;
         wstart      <= 1'b0;
         waddr       <= '0;
         wdata_len   <= '0;
         wdata_vld   <= 1'b0;
         wdata       <= '0;
         last_q      <= IDXW'(NUM_CH - 1);
         owner_q     <= '0;
         beats_q     <= '0;
         cnt_q       <= '0;
         seen_busy_q <= 1'b0;
      end else begin
         ch_gnt    <= '0;
         wstart    <= 1'b0;
         wdata_vld <= 1'b0;
         if (arb_go) begin
            ch_gnt <= NUM_CH'(1) << sel;
            last_q <= sel;
            if (sel_len != '0) begin
               wstart    <= 1'b1;
               waddr     <= sel_addr;
               wdata_len <= sel_len;
               owner_q   <= sel;
               beats_q   <= sel_beats;
               cnt_q     <= '0;
            end
         end
         if (beat_fwd) begin
            wdata_vld <= 1'b1;
            wdata     <= owner_data;
            cnt_q     <= cnt_q + CNTW'(1);
         end
         // A stale wready=1 left over from before wstart must not release
         // the channel; require a busy (wready=0) cycle first.
         if (state_d == IDLE)  seen_busy_q <= 1'b0;
         else if (!wready)     seen_busy_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Self-checking bench for ddr_wr_arbiter: behavioural clients and a
// round-robin / beat-count reference model.
module tb_ddr_wr_arbiter;

   localparam int NUM_CH = 4;
   localparam int DW     = 64;
   localparam int AW     = 32;
   localparam int LW     = 16;
   localparam int BYTES  = DW / 8;

   logic                 clk  = 1'b0;
   logic                 rstn = 1'b0;
   logic                 wready = 1'b0;
   logic [NUM_CH-1:0]    ch_req = '0;
   logic [NUM_CH*AW-1:0] ch_addr;
   logic [NUM_CH*LW-1:0] ch_len;
   logic [NUM_CH-1:0]    ch_gnt, ch_busy, ch_wdata_vld;
   logic [NUM_CH*DW-1:0] ch_wdata;
   logic                 wstart, wdata_vld;
   logic [AW-1:0]        waddr;
   logic [LW-1:0]        wdata_len;
   logic [DW-1:0]        wdata;

   logic [AW-1:0] a_addr [NUM_CH];
   logic [LW-1:0] a_len  [NUM_CH];
   logic [DW-1:0] d_data [NUM_CH];
   logic          d_vld  [NUM_CH];

   int n_tests = 0;
   int n_fail  = 0;
   int m_last;

   ddr_wr_arbiter #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rstn(rstn),
      .ch_req(ch_req), .ch_addr(ch_addr), .ch_len(ch_len),
      .ch_gnt(ch_gnt), .ch_busy(ch_busy),
      .ch_wdata_vld(ch_wdata_vld), .ch_wdata(ch_wdata),
      .wstart(wstart), .wready(wready),
      .waddr(waddr), .wdata_len(wdata_len),
      .wdata_vld(wdata_vld), .wdata(wdata)
   );

   always #5 clk = ~clk;

   // Pack per-client arrays onto the flat buses
   always_comb begin
      ch_addr      = '0;
      ch_len       = '0;
      ch_wdata     = '0;
      ch_wdata_vld = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_addr[i*AW +: AW]  = a_addr[i];
         ch_len[i*LW +: LW]   = a_len[i];
         ch_wdata[i*DW +: DW] = d_data[i];
         ch_wdata_vld[i]      = d_vld[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference: first requester after the last granted channel, wrapping
   function automatic int model_pick();
      for (int k = 1; k <= NUM_CH; k++)
         if (ch_req[(m_last + k) % NUM_CH]) return (m_last + k) % NUM_CH;
      return -1;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_gnt"},   64'(ch_gnt),    64'd0);
      chk({tag, "_busy"},  64'(ch_busy),   64'd0);
      chk({tag, "_wstart"},64'(wstart),    64'd0);
      chk({tag, "_waddr"}, 64'(waddr),     64'd0);
      chk({tag, "_wlen"},  64'(wdata_len), 64'd0);
      chk({tag, "_wvld"},  64'(wdata_vld), 64'd0);
      chk({tag, "_wdata"}, 64'(wdata),     64'd0);
   endtask

   task automatic clear_data();
      for (int i = 0; i < NUM_CH; i++) begin
         d_vld[i]  = 1'b0;
         d_data[i] = '0;
      end
   endtask

   // Wait for a grant, check it against the model, run the burst with
   // random owner gaps and non-owner noise, then release the channel.
   task automatic serve(input bit stale, input int extra, output int got);
      int   exp_ch, beats, drv, sent;
      bit   found, exp_v;
      logic [DW-1:0] exp_d;
      got   = -1;
      found = 1'b0;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (ch_gnt != '0) begin
            found = 1'b1;
            break;
         end
      end
      chk("gnt_seen", 64'(found), 64'd1);
      if (!found) return;
      exp_ch = model_pick();
      chk("gnt_sel", 64'(ch_gnt), (exp_ch < 0) ? 64'hdead : (64'd1 << exp_ch));
      if (exp_ch < 0) return;
      got    = exp_ch;
      m_last = exp_ch;
      ch_req[exp_ch] = 1'b0;
      if (a_len[exp_ch] == '0) begin
         chk("zl_wstart", 64'(wstart),  64'd0);
         chk("zl_busy",   64'(ch_busy), 64'd0);
         tick();
         chk("zl_idle_busy", 64'(ch_busy), 64'd0);
         chk("zl_no_regnt",  64'(ch_gnt),  64'd0);
         chk("zl_no_wstart", 64'(wstart),  64'd0);
         return;
      end
      chk("wstart",     64'(wstart),    64'd1);
      chk("waddr",      64'(waddr),     64'(a_addr[exp_ch]));
      chk("wdata_len",  64'(wdata_len), 64'(a_len[exp_ch]));
      chk("busy_grant", 64'(ch_busy),   64'd1 << exp_ch);
      wready = stale;
      beats  = (int'(a_len[exp_ch]) + BYTES - 1) / BYTES;
      drv    = 0;
      sent   = 0;
      for (int cyc = 0; cyc < 1000 && drv < beats + extra; cyc++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            d_vld[i]  = 1'($urandom);
            d_data[i] = {$urandom, $urandom};
         end
         d_vld[exp_ch] = ($urandom_range(0, 2) != 0);
         exp_v = 1'b0;
         exp_d = '0;
         if (d_vld[exp_ch]) begin
            drv++;
            if (sent < beats) begin
               exp_v = 1'b1;
               exp_d = d_data[exp_ch];
               sent++;
            end
         end
         tick();
         chk("fwd_vld", 64'(wdata_vld), 64'(exp_v));
         if (exp_v) chk("fwd_data", 64'(wdata), 64'(exp_d));
         chk("busy_data",    64'(ch_busy), 64'd1 << exp_ch);
         chk("no_gnt_busy",  64'(ch_gnt),  64'd0);
         chk("wstart_pulse", 64'(wstart),  64'd0);
      end
      clear_data();
      if (stale) begin
         for (int h = 0; h < 2; h++) begin
            tick();
            chk("stale_hold", 64'(ch_busy), 64'd1 << exp_ch);
         end
         wready = 1'b0;
         tick();
         chk("stale_low", 64'(ch_busy), 64'd1 << exp_ch);
      end
      wready = 1'b1;
      tick();
      chk("release_idle", 64'(ch_busy),   64'd0);
      chk("release_vld",  64'(wdata_vld), 64'd0);
   endtask

   initial begin
      int got;
      int exp_order [5];
      bit found;
      exp_order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NUM_CH; i++) begin
         a_addr[i] = '0;
         a_len[i]  = '0;
      end
      clear_data();
      m_last = NUM_CH - 1;

      // Reset state
      tick();
      tick();
      check_zero("reset");
      rstn   = 1'b1;
      wready = 1'b1;

      // Contention: all four request continuously
      for (int i = 0; i < NUM_CH; i++) begin
         a_addr[i] = $urandom;
         a_len[i]  = LW'($urandom_range(1, 60));
      end
      ch_req = '1;
      for (int n = 0; n < 5; n++) begin
         serve(1'($urandom), $urandom_range(0, 1), got);
         chk("rr_order", 64'(got), 64'(exp_order[n]));
         if (got >= 0) begin
            a_addr[got] = $urandom;
            a_len[got]  = LW'($urandom_range(1, 60));
            ch_req[got] = 1'b1;
         end
      end
      // Drain the remaining requesters
      for (int n = 0; n < 3; n++) serve(1'b0, 0, got);
      ch_req = '0;

      // Single client: 64 bytes at 0x1000, wready goes 0 then 1
      a_addr[0] = 32'h1000;
      a_len[0]  = 16'd64;
      ch_req[0] = 1'b1;
      serve(1'b0, 0, got);
      chk("single_ch", 64'(got), 64'd0);

      // Zero length on ch2, then ch3 must win over ch0
      a_len[2]  = '0;
      ch_req[2] = 1'b1;
      serve(1'b0, 0, got);
      chk("zl_ch", 64'(got), 64'd2);
      a_addr[0] = $urandom; a_len[0] = 16'd16;
      a_addr[3] = $urandom; a_len[3] = 16'd24;
      ch_req = 4'b1001;
      serve(1'b0, 0, got);
      chk("after_zl", 64'(got), 64'd3);
      serve(1'b0, 0, got);

      // Partial beat: 20 bytes -> 3 beats, two surplus owner beats dropped
      a_addr[1] = $urandom;
      a_len[1]  = 16'd20;
      ch_req[1] = 1'b1;
      serve(1'b0, 2, got);

      // Stale wready held high through the burst
      a_addr[2] = $urandom;
      a_len[2]  = LW'($urandom_range(1, 64));
      ch_req[2] = 1'b1;
      serve(1'b1, 1, got);

      // Random request mixes
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NUM_CH; i++)
            if (!ch_req[i] && ($urandom_range(0, 1) != 0)) begin
               a_addr[i] = $urandom;
               a_len[i]  = LW'($urandom_range(0, 80));
               ch_req[i] = 1'b1;
            end
         if (ch_req == '0) begin
            a_addr[0] = $urandom;
            a_len[0]  = 16'd8;
            ch_req[0] = 1'b1;
         end
         serve(1'($urandom), $urandom_range(0, 2), got);
      end
      while (ch_req != '0) serve(1'b0, 0, got);

      // Reset in the middle of an 8-beat burst on ch1
      a_addr[1] = $urandom | 32'h10;
      a_len[1]  = 16'd64;
      ch_req[1] = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (ch_gnt != '0) begin
            found = 1'b1;
            break;
         end
      end
      chk("rst_gnt_seen", 64'(found), 64'd1);
      chk("rst_gnt", 64'(ch_gnt), 64'd2);
      ch_req = '0;
      wready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         d_vld[1]  = 1'b1;
         d_data[1] = {$urandom, $urandom};
         tick();
      end
      chk("pre_rst_vld", 64'(wdata_vld), 64'd1);
      #2 rstn = 1'b0;
      #1 check_zero("rst_mid");
      clear_data();
      m_last = NUM_CH - 1;
      tick();
      tick();
      rstn   = 1'b1;
      wready = 1'b1;
      a_addr[0] = $urandom; a_len[0] = 16'd32;
      a_addr[3] = $urandom; a_len[3] = 16'd32;
      ch_req = 4'b1001;
      serve(1'b0, 0, got);
      chk("rst_prio", 64'(got), 64'd0);
      serve(1'b0, 0, got);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
